// File: rtl/mul_div_sequencer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module  : mul_div_sequencer
// Brief   : Multi-cycle MULT/MULTU/DIV/DIVU that borrows the shared ALU per iteration
// Revision: 1.0 - initial release
// ----------------------------------------------------------------------------
module mul_div_sequencer #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] opA,
  input  logic [WIDTH-1:0] opB,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             divByZero,
  output logic [WIDTH-1:0] aluIn1,
  output logic [WIDTH-1:0] aluIn2,
  output logic [3:0]       aluOpCode,
  output logic [4:0]       aluShiftAmt,
  input  logic [WIDTH-1:0] aluResult
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PREP = 3'd1,
    S_ITER = 3'd2,
    S_FIX  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] c_last = CNT_W'(WIDTH - 1);
  localparam logic [3:0]       c_alu_add = 4'd0;
  localparam logic [3:0]       c_alu_sub = 4'd1;

  state_t               r_state;
  logic [1:0]           r_op;
  logic [WIDTH-1:0]     r_opa;
  logic [WIDTH-1:0]     r_opb;
  logic [WIDTH-1:0]     r_b;
  logic [WIDTH-1:0]     r_acc;
  logic [WIDTH-1:0]     r_lo;
  logic [CNT_W-1:0]     r_cnt;
  logic                 r_signq;
  logic                 r_signr;

  logic                 w_is_div;
  logic                 w_sign_a;
  logic                 w_sign_b;
  logic [WIDTH-1:0]     w_abs_a;
  logic [WIDTH-1:0]     w_abs_b;
  logic                 w_divz;
  logic                 w_iter;
  logic [WIDTH-1:0]     w_rshift;
  logic                 w_rout;
  logic                 w_ge;
  logic                 w_carry;
  logic [2*WIDTH-1:0]   w_prod;
  logic [2*WIDTH-1:0]   w_prod_neg;

  // op[1] selects divide, op[0] selects unsigned
  assign w_is_div = r_op[1];
  assign w_sign_a = ~r_op[0] & r_opa[WIDTH-1];
  assign w_sign_b = ~r_op[0] & r_opb[WIDTH-1];
  assign w_abs_a  = w_sign_a ? -r_opa : r_opa;
  assign w_abs_b  = w_sign_b ? -r_opb : r_opb;
  assign w_divz   = w_is_div && (r_opb == '0);
  assign w_iter   = (r_state == S_ITER);

  // Remainder shifted left with the next dividend bit; rOut is the bit lost off the top
  assign w_rshift = {r_acc[WIDTH-2:0], r_lo[WIDTH-1]};
  assign w_rout   = r_acc[WIDTH-1];
  assign w_ge     = w_rout | (w_rshift >= r_b);

  assign aluIn1      = !w_iter ? '0 : (w_is_div ? w_rshift : r_acc);
  assign aluIn2      = !w_iter ? '0 : ((w_is_div || r_lo[0]) ? r_b : '0);
  assign aluOpCode   = (w_iter && w_is_div) ? c_alu_sub : c_alu_add;
  assign aluShiftAmt = '0;

  // Carry-out of the 32-bit add, recovered from the operand and result sign bits
  assign w_carry = (aluIn1[WIDTH-1] & aluIn2[WIDTH-1]) |
                   ((aluIn1[WIDTH-1] | aluIn2[WIDTH-1]) & ~aluResult[WIDTH-1]);

  assign w_prod     = {r_acc, r_lo};
  assign w_prod_neg = -w_prod;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_op      <= '0;
      r_opa     <= '0;
      r_opb     <= '0;
      r_b       <= '0;
      r_acc     <= '0;
      r_lo      <= '0;
      r_cnt     <= '0;
      r_signq   <= 1'b0;
      r_signr   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      divByZero <= 1'b0;
      hi        <= '0;
      lo        <= '0;
    end else begin
      done <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_op      <= op;
            r_opa     <= opA;
            r_opb     <= opB;
            divByZero <= 1'b0;
            busy      <= 1'b1;
            r_state   <= S_PREP;
          end else begin
            r_state   <= S_IDLE;
          end
        end
        S_PREP: begin
          r_signq <= w_sign_a ^ w_sign_b;
          r_signr <= w_sign_a;
          r_acc   <= '0;
          r_cnt   <= '0;
          if (w_is_div) begin
            r_b  <= w_abs_b;
            r_lo <= w_abs_a;
          end else begin
            r_b  <= w_abs_a;
            r_lo <= w_abs_b;
          end
          r_state <= w_divz ? S_FIX : S_ITER;
        end
        S_ITER: begin
          r_cnt <= r_cnt + CNT_W'(1);
          if (w_is_div) begin
            r_acc <= w_ge ? aluResult : w_rshift;
            r_lo  <= {r_lo[WIDTH-2:0], w_ge};
          end else begin
            r_acc <= {w_carry, aluResult[WIDTH-1:1]};
            r_lo  <= {aluResult[0], r_lo[WIDTH-1:1]};
          end
          if (r_cnt == c_last) begin
            r_state <= S_FIX;
          end
        end
        S_FIX: begin
          busy    <= 1'b0;
          done    <= 1'b1;
          r_state <= S_DONE;
          if (w_divz) begin
            hi        <= r_opa;
            lo        <= '1;
            divByZero <= 1'b1;
          end else if (w_is_div) begin
            lo <= r_signq ? -r_lo : r_lo;
            hi <= r_signr ? -r_acc : r_acc;
          end else if (r_signq) begin
            {hi, lo} <= w_prod_neg;
          end else begin
            {hi, lo} <= w_prod;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mul_div_sequencer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module  : tb_mul_div_sequencer
// Brief   : Directed and random checks of mul_div_sequencer against an arithmetic model
// Revision: 1.0 - initial release
// ----------------------------------------------------------------------------
module tb_mul_div_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] opA;
  logic [31:0] opB;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        divByZero;
  logic [31:0] aluIn1;
  logic [31:0] aluIn2;
  logic [3:0]  aluOpCode;
  logic [4:0]  aluShiftAmt;
  logic [31:0] aluResult;

  int          checks   = 0;
  int          failures = 0;
  logic [31:0] exp_hi   = '0;
  logic [31:0] exp_lo   = '0;

  mul_div_sequencer #(.WIDTH(32), .CNT_W(5)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .op         (op),
    .opA        (opA),
    .opB        (opB),
    .busy       (busy),
    .done       (done),
    .hi         (hi),
    .lo         (lo),
    .divByZero  (divByZero),
    .aluIn1     (aluIn1),
    .aluIn2     (aluIn2),
    .aluOpCode  (aluOpCode),
    .aluShiftAmt(aluShiftAmt),
    .aluResult  (aluResult)
  );

  always #5 clk = ~clk;

  // Shared ALU stand-in: add for opcode 0, subtract for opcode 1
  assign aluResult = (aluOpCode == 4'd1) ? (aluIn1 - aluIn2) : (aluIn1 + aluIn2);

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Returns {divByZero, hi, lo} straight from MIPS arithmetic semantics
  function automatic logic [64:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa;
    logic signed [63:0] sb;
    logic [63:0]        p;
    logic signed [63:0] q;
    logic signed [63:0] r;
    sa = 64'(signed'(a));
    sb = 64'(signed'(b));
    case (o)
      2'b00: begin
        p = sa * sb;
        return {1'b0, p};
      end
      2'b01: begin
        p = {32'b0, a} * {32'b0, b};
        return {1'b0, p};
      end
      default: begin
        if (b == 32'd0) return {1'b1, a, 32'hFFFF_FFFF};
        if (o == 2'b10) begin
          q = sa / sb;
          r = sa % sb;
          return {1'b0, r[31:0], q[31:0]};
        end
        return {1'b0, a % b, a / b};
      end
    endcase
  endfunction

  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input bit b2b, input int inject);
    logic [64:0] m;
    int          lat;
    bit          seen;
    m    = model(o, a, b);
    lat  = (o[1] && b == 32'd0) ? 2 : 34;
    seen = 1'b0;
    if (!b2b) @(negedge clk);
    op    = o;
    opA   = a;
    opB   = b;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    op    = 2'($urandom_range(3, 0));
    opA   = $urandom;
    opB   = $urandom;
    check("busy_after_start", 64'(busy), 64'(1));
    check("flag_cleared_on_start", 64'(divByZero), 64'(0));
    check("alu_idle_in_prep", {28'(0), aluOpCode, aluIn1 | aluIn2}, 64'(0));
    check("hi_lo_held_over_start", {hi, lo}, {exp_hi, exp_lo});
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      start = (k == inject);
      if (k == 5 && lat == 34) check("alu_opcode_in_iter", 64'(aluOpCode), o[1] ? 64'(1) : 64'(0));
      if (done) begin
        seen = 1'b1;
        check("done_latency_edges", 64'(k), 64'(lat));
        break;
      end
    end
    if (!seen) begin
      checks++;
      failures++;
      $error("FAIL done_timeout observed=no_done expected=done_within_40");
    end
    check("hi_lo_result", {hi, lo}, m[63:0]);
    check("div_by_zero_flag", 64'(divByZero), 64'(m[64]));
    check("busy_low_at_done", 64'(busy), 64'(0));
    check("alu_idle_at_done", {23'(0), aluShiftAmt, aluOpCode, aluIn1 | aluIn2}, 64'(0));
    exp_hi = m[63:32];
    exp_lo = m[31:0];
  endtask

  initial begin
    int dones;
    logic [1:0]  ro;
    logic [31:0] ra;
    logic [31:0] rb;
    rst   = 1'b1;
    start = 1'b0;
    op    = 2'b00;
    opA   = '0;
    opB   = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy_done_flag", {61'(0), busy, done, divByZero}, 64'(0));
    check("reset_hi_lo", {hi, lo}, 64'(0));
    check("reset_alu_outputs", {23'(0), aluShiftAmt, aluOpCode, aluIn1 | aluIn2}, 64'(0));
    @(negedge clk);
    rst = 1'b0;

    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, -1);
    @(posedge clk);
    #1;
    check("done_single_cycle", 64'(done), 64'(0));
    run_op(2'b00, 32'hFFFF_FFFB, 32'd7, 1'b0, -1);
    run_op(2'b00, 32'h8000_0000, 32'h8000_0000, 1'b0, -1);
    run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 1'b0, -1);
    run_op(2'b11, 32'd100, 32'd7, 1'b0, -1);
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, -1);
    run_op(2'b10, 32'd5, 32'd0, 1'b0, -1);
    run_op(2'b11, 32'd3, 32'd9, 1'b0, -1);
    run_op(2'b11, 32'hDEAD_BEEF, 32'd0, 1'b0, -1);
    run_op(2'b00, 32'd1234, 32'hFFFF_EA1F, 1'b0, 10);
    run_op(2'b11, 32'd100, 32'd7, 1'b0, -1);
    run_op(2'b00, 32'hFFFF_FFFD, 32'hFFFF_FFF7, 1'b1, -1);
    run_op(2'b10, 32'd7, 32'hFFFF_FFFE, 1'b1, -1);

    for (int i = 0; i < 30; i++) begin
      ro = 2'($urandom_range(3, 0));
      ra = ($urandom_range(0, 5) == 0) ? 32'h8000_0000 : $urandom;
      rb = ($urandom_range(0, 6) == 0) ? 32'd0 :
           ($urandom_range(0, 2) == 0) ? 32'($urandom_range(1, 300)) : $urandom;
      run_op(ro, ra, rb, 1'b0, -1);
    end

    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, -1);
    @(negedge clk);
    op    = 2'b01;
    opA   = 32'h1234_5678;
    opB   = 32'h9ABC_DEF0;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("abort_busy_done", {62'(0), busy, done}, 64'(0));
    check("abort_hi_lo_cleared", {hi, lo}, 64'(0));
    dones = 0;
    repeat (3) begin
      @(posedge clk);
      #1;
      if (done) dones++;
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done) dones++;
    end
    check("no_done_after_abort", 64'(dones), 64'(0));
    exp_hi = '0;
    exp_lo = '0;
    run_op(2'b11, 32'd100, 32'd7, 1'b0, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
